// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, oversampling constants, parity helper.
// Parity support is compiled in with UART_RX_PARITY_EN.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;

  function automatic logic even_par_ok(input logic [7:0] dat, input logic par);
    return ~(^{dat, par});
  endfunction
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} rx_state_e;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, combinational head read (zero read latency), write visible next cycle.
// Backpressure: wr_rdy_o drops when full unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_vld_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic             wr_rdy_o,
  output logic             rd_vld_o,
  output logic [WIDTH-1:0] rd_dat_o,
  input  logic             rd_rdy_i
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full, rd_fire, wr_fire;

  // Extra MSB on each pointer tells a full ring apart from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign rd_fire  = !empty && rd_rdy_i;
  assign wr_rdy_o = !full || rd_fire;
  assign wr_fire  = wr_vld_i && wr_rdy_o;

  assign rd_vld_o = !empty;
  assign rd_dat_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_fire};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_fire};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled 8N1 UART receiver into a sync_fifo; byte pushed 1 cycle after stop sample, visible 1 cycle later.
// No backpressure on the line: a push into a full FIFO without a pop is dropped and flags overrun. Optional UART_RX_PARITY_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_tick_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       clr_err_i
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err_o
`endif
);

  localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
  localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  rx_state_e              state_q, state_d;
  logic [3:0]             tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   push_q, push_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   set_ferr, fifo_wr_rdy, rx_s;
`ifdef UART_RX_PARITY_EN
  logic                   par_ok_q, par_ok_d;
  logic                   parity_err_q, parity_err_d;
  logic                   set_perr;
`endif

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_i};
  assign rx_s   = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_d   = 1'b0;
    set_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_d = par_ok_q;
    set_perr = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_tick_i && !rx_s) begin
          state_d = ST_START;
          tick_d  = '0;
        end
      end
      ST_START: begin
        if (rx_tick_i) begin
          if (tick_q == MID_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            // A start bit that is high again at mid-bit was a glitch.
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (rx_tick_i) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (rx_tick_i) begin
          if (tick_q == BIT_LAST) begin
            tick_d   = '0;
            state_d  = ST_STOP;
            par_ok_d = even_par_ok(shift_q, rx_s);
            set_perr = !even_par_ok(shift_q, rx_s);
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (rx_tick_i) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            state_d = ST_IDLE;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              push_d = par_ok_q;
`else
              push_d = 1'b1;
`endif
            end else begin
              set_ferr = 1'b1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A fresh error event takes priority over a coincident clear.
  always_comb begin
    frame_err_d  = set_ferr | (frame_err_q & ~clr_err_i);
    overrun_d    = (push_q & ~fifo_wr_rdy) | (overrun_q & ~clr_err_i);
`ifdef UART_RX_PARITY_EN
    parity_err_d = set_perr | (parity_err_q & ~clr_err_i);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q       <= '1;
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q     <= 1'b1;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      push_q       <= push_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_ok_q     <= par_ok_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_vld_i (push_q),
    .wr_dat_i (shift_q),
    .wr_rdy_o (fifo_wr_rdy),
    .rd_vld_o (rx_valid_o),
    .rd_dat_o (rx_data_o),
    .rd_rdy_i (rx_ready_i)
  );

  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus sequences for latency, glitch,
// overrun, full-with-pop and mid-frame reset. Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i, rx_tick_i, rx_i, rx_ready_i, clr_err_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, frame_err_o, overrun_o;
  int         checks = 0;
  int         failures = 0;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
  logic       par_flip = 1'b0;
  localparam int PUSH_EDGE = 171;
`else
  localparam int PUSH_EDGE = 155;
`endif

  uart_rx_fifo #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_tick_i   (rx_tick_i),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .clr_err_i   (clr_err_i)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o(parity_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    logic       exp_vld;
    logic       exp_ferr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start bit driven just after edge P0; data bit i after P(16+16i); stop after P144; line idle after P160.
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    @(posedge clk_i); #1 rx_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(posedge clk_i);
      #1 rx_i = b[i];
    end
`ifdef UART_RX_PARITY_EN
    repeat (16) @(posedge clk_i);
    #1 rx_i = (^b) ^ par_flip;
`endif
    repeat (16) @(posedge clk_i);
    #1 rx_i = stop_b;
    repeat (16) @(posedge clk_i);
    #1 rx_i = 1'b1;
  endtask

  task automatic pulse_pop();
    @(posedge clk_i); #1 rx_ready_i = 1'b1;
    @(posedge clk_i); #1 rx_ready_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk_i); #1 clr_err_i = 1'b1;
    @(posedge clk_i); #1 clr_err_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL global_timeout: simulation did not finish, failures=%0d", failures);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    int   lat;
    vecs[0] = '{dat: 8'hA5, stop: 1'b1, exp_vld: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{dat: 8'h3C, stop: 1'b0, exp_vld: 1'b0, exp_ferr: 1'b1};
    vecs[2] = '{dat: 8'h00, stop: 1'b1, exp_vld: 1'b1, exp_ferr: 1'b0};
    vecs[3] = '{dat: 8'hFF, stop: 1'b1, exp_vld: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{dat: 8'h81, stop: 1'b1, exp_vld: 1'b1, exp_ferr: 1'b0};
    vecs[5] = '{dat: 8'h7E, stop: 1'b0, exp_vld: 1'b0, exp_ferr: 1'b1};

    rst_i = 1'b1; rx_tick_i = 1'b1; rx_i = 1'b1; rx_ready_i = 1'b0; clr_err_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_valid", 32'(rx_valid_o), 32'd0);
    chk("reset_data", 32'(rx_data_o), 32'd0);
    chk("reset_ferr", 32'(frame_err_o), 32'd0);
    chk("reset_ovr", 32'(overrun_o), 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (5) @(posedge clk_i);

    // 0xA5 latency from start edge to rx_valid_o
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk_i);
        while (lat < 200) begin
          @(negedge clk_i);
          lat++;
          if (rx_valid_o) break;
        end
      end
    join
    chk("a5_latency_le161", (lat <= 161) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk_i);
    chk("a5_data", 32'(rx_data_o), 32'hA5);
    chk("a5_ferr", 32'(frame_err_o), 32'd0);
    chk("a5_ovr", 32'(overrun_o), 32'd0);
    pulse_pop();
    repeat (20) @(posedge clk_i);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].dat, vecs[v].stop);
      repeat (4) @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("vec%0d_valid", v), 32'(rx_valid_o), 32'(vecs[v].exp_vld));
      if (vecs[v].exp_vld) chk($sformatf("vec%0d_data", v), 32'(rx_data_o), 32'(vecs[v].dat));
      chk($sformatf("vec%0d_ferr", v), 32'(frame_err_o), 32'(vecs[v].exp_ferr));
      chk($sformatf("vec%0d_ovr", v), 32'(overrun_o), 32'd0);
      for (int k = 0; k < 4 && rx_valid_o; k++) pulse_pop();
      pulse_clr();
      repeat (20) @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("vec%0d_after_valid", v), 32'(rx_valid_o), 32'd0);
      chk($sformatf("vec%0d_after_ferr", v), 32'(frame_err_o), 32'd0);
    end

    // 4-tick low glitch on idle line
    @(posedge clk_i); #1 rx_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 rx_i = 1'b1;
    repeat (30) @(posedge clk_i);
    @(negedge clk_i);
    chk("glitch_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("glitch_valid", 32'(rx_valid_o), 32'd0);
    chk("glitch_ferr", 32'(frame_err_o), 32'd0);

    // Nine bytes with no consumer: ninth dropped
    for (int b = 0; b < 9; b++) send_frame(8'(b), 1'b1);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    chk("ovr_flag", 32'(overrun_o), 32'd1);
    chk("ovr_ferr", 32'(frame_err_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      chk($sformatf("ovr_drain%0d_valid", i), 32'(rx_valid_o), 32'd1);
      chk($sformatf("ovr_drain%0d_data", i), 32'(rx_data_o), 32'(i));
      pulse_pop();
    end
    @(negedge clk_i);
    chk("ovr_drained_empty", 32'(rx_valid_o), 32'd0);
    pulse_clr();
    @(negedge clk_i);
    chk("ovr_cleared", 32'(overrun_o), 32'd0);

    // Full FIFO, pop on the push cycle of 0x55
    for (int b = 0; b < 8; b++) send_frame(8'h10 + 8'(b), 1'b1);
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk_i);
        repeat (PUSH_EDGE) @(posedge clk_i);
        #1 rx_ready_i = 1'b1;
        @(posedge clk_i); #1 rx_ready_i = 1'b0;
      end
    join
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    chk("fullpop_ovr", 32'(overrun_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      chk($sformatf("fullpop_drain%0d", i), 32'(rx_data_o), (i == 7) ? 32'h55 : 32'(8'h11 + 8'(i)));
      pulse_pop();
    end
    @(negedge clk_i);
    chk("fullpop_empty", 32'(rx_valid_o), 32'd0);

    // Reset after the 4th data bit of 0xFF, with data queued and a flag set
    send_frame(8'h42, 1'b1);
    send_frame(8'h3C, 1'b0);
    repeat (20) @(posedge clk_i);
    @(posedge clk_i); #1 rx_i = 1'b0;
    repeat (16) @(posedge clk_i);
    #1 rx_i = 1'b1;
    repeat (64) @(posedge clk_i);
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("midrst_valid", 32'(rx_valid_o), 32'd0);
    chk("midrst_data", 32'(rx_data_o), 32'd0);
    chk("midrst_ferr", 32'(frame_err_o), 32'd0);
    chk("midrst_ovr", 32'(overrun_o), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (20) @(posedge clk_i);
    send_frame(8'h81, 1'b1);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    chk("postrst_valid", 32'(rx_valid_o), 32'd1);
    chk("postrst_data", 32'(rx_data_o), 32'h81);
    chk("postrst_ferr", 32'(frame_err_o), 32'd0);
`ifdef UART_RX_PARITY_EN
    chk("postrst_perr", 32'(parity_err_o), 32'd0);
    pulse_pop();
    par_flip = 1'b1;
    send_frame(8'h81, 1'b1);
    par_flip = 1'b0;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    chk("badpar_perr", 32'(parity_err_o), 32'd1);
    chk("badpar_valid", 32'(rx_valid_o), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
